// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM bus arbiter: requester ids, order-FIFO entry, default depth.
package sram_arb_pkg;

  typedef enum logic {
    ID_INST = 1'b0,
    ID_DATA = 1'b1
  } arb_id_t;

  typedef struct packed {
    arb_id_t id;
    logic    discard;
  } fifo_entry_t;

  localparam int OUTSTD_DEF = 4;

endpackage

// File: rtl/arb_order_fifo.sv
// Issue-order FIFO of outstanding transactions; the head bypasses a same-cycle push
// when empty, and discard bits can be set in bulk for one requester id.
module arb_order_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = OUTSTD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  logic i_push_id,
  input  logic i_push_discard,
  input  logic i_pop,
  input  logic i_set_discard,
  input  logic i_set_id,
  output logic o_full,
  output logic o_head_vld,
  output logic o_head_id,
  output logic o_head_discard
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  fifo_entry_t   r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          w_empty;
  logic          w_pop;
  fifo_entry_t   w_stored;

  assign w_empty    = (r_count == {(PW+1){1'b0}});
  assign o_full     = (r_count == FULL_CNT);
  assign o_head_vld = ~w_empty | i_push;
  assign w_pop      = i_pop & o_head_vld;

  // Head selection: an empty FIFO presents the entry being pushed this cycle
  always_comb begin
    w_stored = r_mem[r_rptr];
    if (w_empty) begin
      o_head_id      = i_push_id;
      o_head_discard = i_push_discard;
    end else begin
      o_head_id      = w_stored.id;
      o_head_discard = w_stored.discard | (i_set_discard & (w_stored.id == i_set_id));
    end
  end

  // Storage, pointers and occupancy; a push+pop on an empty FIFO passes straight through
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '{id: ID_INST, discard: 1'b0};
      end
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {(PW+1){1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_set_discard && (r_mem[i].id == i_set_id)) begin
          r_mem[i].discard <= 1'b1;
        end
      end
      if (i_push) begin
        r_mem[r_wptr] <= '{id: arb_id_t'(i_push_id), discard: i_push_discard};
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and data access, routing responses
// back in issue order. Define SRAM_ARB_RR_EN for round-robin instead of data-first priority.
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OUTSTD = OUTSTD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [3:0]        inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              inst_flush,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_req,
  output logic              sram_wr,
  output logic [1:0]        sram_size,
  output logic [3:0]        sram_wstrb,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic              sram_addr_ok,
  input  logic              sram_data_ok,
  input  logic [DATA_W-1:0] sram_rdata
);

  logic    r_lock_vld;
  arb_id_t r_lock_id;
  arb_id_t w_gnt_id;
  logic    w_gnt_req;
  logic    w_sram_req;
  logic    w_fifo_full;
  logic    w_push;
  logic    w_pop;
  logic    w_head_vld;
  logic    w_head_id;
  logic    w_head_discard;
`ifdef SRAM_ARB_RR_EN
  arb_id_t r_last_id;
`endif

  // Grant selection: a held lock wins, otherwise arbitrate between live requests
  always_comb begin
    w_gnt_id = ID_DATA;
    if (r_lock_vld) begin
      w_gnt_id = r_lock_id;
    end else if (inst_req && data_req) begin
`ifdef SRAM_ARB_RR_EN
      w_gnt_id = (r_last_id == ID_DATA) ? ID_INST : ID_DATA;
`else
      w_gnt_id = ID_DATA;
`endif
    end else if (inst_req) begin
      w_gnt_id = ID_INST;
    end else begin
      w_gnt_id = ID_DATA;
    end
  end

  assign w_gnt_req  = (w_gnt_id == ID_DATA) ? data_req : inst_req;
  assign w_sram_req = w_gnt_req & ~w_fifo_full & ~reset;
  assign w_push     = w_sram_req & sram_addr_ok;
  assign w_pop      = sram_data_ok & ~reset;

  assign sram_req     = w_sram_req;
  assign inst_addr_ok = w_push & (w_gnt_id == ID_INST);
  assign data_addr_ok = w_push & (w_gnt_id == ID_DATA);
  assign inst_data_ok = w_pop & w_head_vld & (w_head_id == ID_INST) & ~w_head_discard;
  assign data_data_ok = w_pop & w_head_vld & (w_head_id == ID_DATA) & ~w_head_discard;
  assign inst_rdata   = sram_rdata;
  assign data_rdata   = sram_rdata;

  // Slave request fields from the granted requester, zero while nothing is granted
  always_comb begin
    sram_wr    = 1'b0;
    sram_size  = 2'b00;
    sram_wstrb = 4'b0000;
    sram_addr  = {ADDR_W{1'b0}};
    sram_wdata = {DATA_W{1'b0}};
    if (w_gnt_req && !reset) begin
      case (w_gnt_id)
        ID_INST: begin
          sram_wr    = inst_wr;
          sram_size  = inst_size;
          sram_wstrb = inst_wstrb;
          sram_addr  = inst_addr;
          sram_wdata = inst_wdata;
        end
        default: begin
          sram_wr    = data_wr;
          sram_size  = data_size;
          sram_wstrb = data_wstrb;
          sram_addr  = data_addr;
          sram_wdata = data_wdata;
        end
      endcase
    end else begin
      sram_wr = 1'b0;
    end
  end

  // Lock keeps a stalled request's fields stable until the slave takes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock_vld <= 1'b0;
      r_lock_id  <= ID_INST;
    end else if (w_sram_req && !sram_addr_ok) begin
      r_lock_vld <= 1'b1;
      r_lock_id  <= w_gnt_id;
    end else if (w_push) begin
      r_lock_vld <= 1'b0;
    end else if (r_lock_vld && !w_gnt_req) begin
      r_lock_vld <= 1'b0;
    end else begin
      r_lock_vld <= r_lock_vld;
    end
  end

`ifdef SRAM_ARB_RR_EN
  // Remember the last accepted requester so the other one wins the next tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_id <= ID_INST;
    end else if (w_push) begin
      r_last_id <= w_gnt_id;
    end else begin
      r_last_id <= r_last_id;
    end
  end
`endif

  arb_order_fifo #(.DEPTH(OUTSTD)) u_order_fifo (
    .clk            (clk),
    .reset          (reset),
    .i_push         (w_push),
    .i_push_id      (w_gnt_id),
    .i_push_discard (inst_flush & (w_gnt_id == ID_INST)),
    .i_pop          (w_pop),
    .i_set_discard  (inst_flush),
    .i_set_id       (ID_INST),
    .o_full         (w_fifo_full),
    .o_head_vld     (w_head_vld),
    .o_head_id      (w_head_id),
    .o_head_discard (w_head_discard)
  );

endmodule
